// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus/check engine for N-input gates: sweeps all 2^N vectors and
// compares i_dut against a run-time selected reference. Optional: GATE_SWEEP_STOP_ON_ERR_EN.
module gate_sweep_checker #(
  parameter int N    = 4,
  parameter int HOLD = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [1:0]   i_mode,
  output logic [N-1:0] o_vec,
  input  logic         i_dut,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_pass,
  output logic [N:0]   o_err_cnt,
  output logic [N-1:0] o_first_err_vec
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [N-1:0]  first_q, first_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N:0]    err_q, err_d;
  logic          seen_q, seen_d;

  logic ref_bit;
  logic sample;
  logic mismatch;
  logic last_vec;

  always_comb begin
    ref_bit = 1'b0;
    case (mode_q)
      2'b00:   ref_bit = &vec_q;
      2'b01:   ref_bit = |vec_q;
      2'b10:   ref_bit = ~&vec_q;
      default: ref_bit = ~|vec_q;
    endcase
  end

  assign sample   = (state_q == RUN) && (hold_q == HW'(HOLD - 1));
  assign mismatch = sample && (i_dut != ref_bit);
  assign last_vec = &vec_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    first_d = first_q;
    hold_d  = hold_q;
    err_d   = err_q;
    seen_d  = seen_q;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = RUN;
          mode_d  = i_mode;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
        end
      end
      RUN: begin
        if (sample) begin
          hold_d = '0;
          if (mismatch) begin
            err_d = err_q + (N + 1)'(1);
            if (!seen_q) begin
              first_d = vec_q;
              seen_d  = 1'b1;
            end
          end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
          // The failing vector stays on o_vec so it can be inspected in DONE.
          if (mismatch || last_vec) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + N'(1);
          end
`else
          if (last_vec) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + N'(1);
          end
`endif
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      vec_q   <= '0;
      first_q <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      first_q <= first_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
    end
  end

  assign o_vec           = vec_q;
  assign o_busy          = (state_q == RUN);
  assign o_done          = (state_q == DONE);
  assign o_pass          = (state_q == DONE) && (err_q == '0);
  assign o_err_cnt       = err_q;
  assign o_first_err_vec = first_q;

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking exhaustive stimulus engine for the N-input logic gate library: `and_gate`, `and3_gate`, `and4_gate`, `or_gate` and their wider successors. It sweeps every input combination of an N-input gate under test, holds each vector for a programmable number of cycles, and compares the gate output against a reference function selected at run time. It reports mismatch count, first failing vector and pass/fail. It replaces hand-written per-gate truth-table benches with one synthesizable, reusable block.

## Interface
Parameters:
- `N`, default 4: number of gate inputs; legal range 1..8.
- `HOLD`, default 2: cycles each vector is held; legal range ≥1.

Ports:
- `i_clk`, input, 1: clock, rising edge.
- `i_rst`, input, 1: reset, asynchronous, active-high.
- `i_start`, input, 1: start a sweep; accepted only in IDLE or DONE.
- `i_mode`, input, 2: reference function, latched at start. 00 AND, 01 OR, 10 NAND, 11 NOR.
- `o_vec`, output, N: stimulus to the gate inputs; `o_vec[0]` drives `i_1`, `o_vec[1]` drives `i_2`, and so on.
- `i_dut`, input, 1: gate output `o`.
- `o_busy`, output, 1: sweep in progress.
- `o_done`, output, 1: sweep finished; held until the next accepted start or reset.
- `o_pass`, output, 1: `o_done` && `o_err_cnt` == 0.
- `o_err_cnt`, output, N+1: number of mismatching vectors (max 2^N).
- `o_first_err_vec`, output, N: first vector that mismatched; 0 if none.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on `i_start`.
  - `i_mode` is latched.
  - `o_vec`, the hold counter and `o_err_cnt` are cleared to 0.
  - `o_first_err_vec` is cleared to 0 and a first-error-seen flag is cleared.
- RUN: `o_vec` counts binary upward from 0 to 2^N−1.
  - The hold counter runs 0..HOLD−1.
  - On the cycle where hold == HOLD−1, `i_dut` is sampled and compared with `ref(o_vec, mode)`, then `o_vec` increments.
  - A mismatch increments `o_err_cnt`. On the first mismatch only, `o_vec` is captured into `o_first_err_vec`.
- RUN -> DONE after the sample of vector 2^N−1. `o_vec` holds 2^N−1 in DONE and does not wrap to 0.
- DONE -> RUN on `i_start`, with the same clearing as IDLE -> RUN. There is no DONE -> IDLE transition except by reset.
- In RUN, `i_start` and changes on `i_mode` are ignored.
- Reference function: AND = &vec, OR = |vec, NAND = ~&vec, NOR = ~|vec.
- When N = 1, AND and OR reduce to a buffer, and NAND and NOR to an inverter.
- `o_err_cnt` never saturates; width N+1 holds 2^N.

## Timing
- Reset values: `o_vec` = 0, `o_busy` = 0, `o_done` = 0, `o_pass` = 0, `o_err_cnt` = 0, `o_first_err_vec` = 0. State is IDLE, latched mode is 00.
- Reset asserted mid-sweep forces these values immediately, without waiting for a clock edge. The sweep does not resume.
- `i_start` sampled high at edge k:
  - `o_busy` = 1 and `o_vec` = 0 from k+1.
  - Vector v is driven during cycles k+1+v·HOLD through k+(v+1)·HOLD.
  - `i_dut` is sampled at the last edge of that window, so combinational gates see HOLD−1 cycles of settling. With HOLD = 1 the sample is taken on the same cycle the vector is driven.
- `o_done` = 1 and `o_busy` = 0 from edge k+2^N·HOLD+1. Total latency is 2^N·HOLD+1 cycles.
- All outputs are registered; no combinational path from `i_dut` to any output.
- `o_err_cnt` and `o_first_err_vec` update one cycle after the sample edge. They are final when `o_done` rises.
- `o_busy` and `o_done` are never high together.

## Configuration
- `GATE_SWEEP_STOP_ON_ERR_EN`:
  - Defined: the first mismatch moves RUN -> DONE on the cycle after that sample. `o_err_cnt` = 1, `o_pass` = 0, and `o_vec` holds the failing vector.
  - Undefined: the full 2^N sweep always completes and all mismatches are counted.
  - Reset, handshake and DONE behaviour are otherwise identical.

## Test plan
All scenarios use N = 4, HOLD = 2 and the macro undefined unless stated.
- **Correct AND:** `and4_gate` driven by `o_vec`, mode 00, start pulse -> `o_busy` for 32 cycles, `o_done` at start+33, `o_err_cnt` = 0, `o_pass` = 1, `o_first_err_vec` = 0.
- **Stuck-at-0 under OR:** `i_dut` tied 0, mode 01 -> `o_err_cnt` = 15, `o_first_err_vec` = 4'b0001, `o_pass` = 0.
- **Stuck-at-1 under NAND:** `i_dut` tied 1, mode 10 -> `o_err_cnt` = 1, `o_first_err_vec` = 4'b1111.
- **Stop on error:** macro defined, `i_dut` tied 0, mode 11 (NOR) -> DONE immediately after vector 0 is sampled; `o_err_cnt` = 1, `o_first_err_vec` = 0, `o_vec` = 0.
- **Ignored inputs and restart:**
  - Mid-sweep start pulse and `i_mode` toggles during RUN -> no effect on the result.
  - A new start in DONE -> counters cleared, `o_done` drops at the next edge, and the sweep reruns.
- **Reset mid-sweep:** `i_rst` asserted at vector 7 -> all outputs 0 without waiting for a clock edge; after release, the block stays IDLE until `i_start`.
